pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control.sv | 279 +++++++++++++++++++++++++++
 tb/tb_pipe_control.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// Pipelined control unit: decodes the ID instruction, carries its control word
// through EX/MEM/WB, and resolves RAW, load-use and redirect hazards.
package pipe_control_pkg;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_J    = 7'b1101111;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JAL  = 2'd2;
    localparam logic [1:0] NPC_JALR = 2'd3;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BLT  = 4'd12;
    localparam logic [3:0] ALU_BGE  = 4'd13;
    localparam logic [3:0] ALU_BLTU = 4'd14;
    localparam logic [3:0] ALU_BGEU = 4'd15;

    localparam logic [2:0] SEXT_I = 3'd0;
    localparam logic [2:0] SEXT_S = 3'd1;
    localparam logic [2:0] SEXT_B = 3'd2;
    localparam logic [2:0] SEXT_U = 3'd3;
    localparam logic [2:0] SEXT_J = 3'd4;

    localparam logic ALU_B_RD2 = 1'b0;
    localparam logic ALU_B_EXT = 1'b1;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_RAM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_EXT = 2'd3;

    typedef struct packed {
        logic [1:0] npc_sel;
        logic [3:0] alu_op;
        logic       opb_sel;
        logic       ram_we;
        logic       rf_we;
        logic [1:0] rf_wsel;
        logic [4:0] rd;
        logic       is_lw;
    } ctrl_t;
endpackage

module pipe_control
    import pipe_control_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int XREGS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic        ex_taken,
    output logic [1:0]  ex_npc_sel,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_opB_sel,
    output logic [2:0]  id_sext_op,
    output logic        mem_ram_we,
    output logic        wb_rf_we,
    output logic [1:0]  wb_rf_wsel,
    output logic [4:0]  wb_rd,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        stall,
    output logic        flush,
    output logic        illegal
);
    localparam int AW = (XREGS > 1) ? $clog2(XREGS) : 1;

    // Register-index equality on the architected width; x0 never matches.
    function automatic logic same_reg(input logic [4:0] rs, input logic [4:0] rd);
        return (rs[AW-1:0] != '0) && (rs[AW-1:0] == rd[AW-1:0]);
    endfunction

    function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic f7b5, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [3:0] alu_branch(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_BEQ;
            3'b001:  return ALU_BNE;
            3'b100:  return ALU_BLT;
            3'b101:  return ALU_BGE;
            3'b110:  return ALU_BLTU;
            default: return ALU_BGEU;
        endcase
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic mem_ok, input logic [4:0] mrd,
                                           input logic wb_ok, input logic [4:0] wrd);
        if (mem_ok && same_reg(rs, mrd)) return 2'd1;
        if (wb_ok && same_reg(rs, wrd))  return 2'd2;
        return 2'd0;
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7b5;
    logic       unused_bits;
    assign opcode      = id_inst[6:0];
    assign f3          = id_inst[14:12];
    assign f7b5        = id_inst[30];
    assign unused_bits = ^{id_inst[31], id_inst[29:25]};

    ctrl_t      id_cw;
    logic       id_legal, rs1_used, rs2_used, writes_rd;
    logic [4:0] id_rs1, id_rs2;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        id_cw      = '0;
        id_sext_op = SEXT_I;
        id_legal   = 1'b1;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        writes_rd  = 1'b0;
        case (opcode)
            OP_R: begin
                id_cw.alu_op = alu_arith(f3, f7b5, 1'b1);
                rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1;
            end
            OP_I: begin
                id_cw.alu_op  = alu_arith(f3, f7b5, 1'b0);
                id_cw.opb_sel = ALU_B_EXT;
                rs1_used = 1'b1; writes_rd = 1'b1;
            end
            OP_LW: begin
                id_cw.opb_sel = ALU_B_EXT;
                id_cw.rf_wsel = WB_RAM;
                id_cw.is_lw   = 1'b1;
                rs1_used = 1'b1; writes_rd = 1'b1;
            end
            OP_JALR: begin
                id_cw.npc_sel = NPC_JALR;
                id_cw.opb_sel = ALU_B_EXT;
                id_cw.rf_wsel = WB_PC4;
                rs1_used = 1'b1; writes_rd = 1'b1;
            end
            OP_SW: begin
                id_sext_op    = SEXT_S;
                id_cw.opb_sel = ALU_B_EXT;
                id_cw.ram_we  = 1'b1;
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OP_B: begin
                id_sext_op    = SEXT_B;
                id_cw.npc_sel = NPC_BR;
                id_cw.alu_op  = alu_branch(f3);
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OP_U: begin
                id_sext_op    = SEXT_U;
                id_cw.opb_sel = ALU_B_EXT;
                id_cw.rf_wsel = WB_EXT;
                writes_rd = 1'b1;
            end
            OP_J: begin
                id_sext_op    = SEXT_J;
                id_cw.npc_sel = NPC_JAL;
                id_cw.rf_wsel = WB_PC4;
                writes_rd = 1'b1;
            end
            default: id_legal = 1'b0;
        endcase
        id_cw.rd    = id_inst[11:7];
        id_cw.rf_we = writes_rd && (id_inst[AW+6:7] != '0);
    end

    assign illegal = id_valid && !id_legal;
    assign id_rs1  = (id_valid && rs1_used) ? id_inst[19:15] : 5'd0;
    assign id_rs2  = (id_valid && rs2_used) ? id_inst[24:20] : 5'd0;

    ctrl_t      ex_cw;
    logic       ex_valid, mem_valid, wb_valid;
    logic [4:0] ex_rs1, ex_rs2;
    logic       mem_ram_we_q, mem_rf_we, mem_is_lw, wb_rf_we_q;
    logic [1:0] mem_rf_wsel, wb_rf_wsel_q;
    logic [4:0] mem_rd, wb_rd_q;

    logic ex_hit, mem_hit, hazard;
    always_comb begin
        ex_hit  = ex_valid && ex_cw.rf_we &&
                  (same_reg(id_rs1, ex_cw.rd) || same_reg(id_rs2, ex_cw.rd));
        mem_hit = mem_valid && mem_rf_we &&
                  (same_reg(id_rs1, mem_rd) || same_reg(id_rs2, mem_rd));
        hazard  = FWD_EN ? (ex_hit && ex_cw.is_lw) : (ex_hit || mem_hit);
    end

    // A redirect discards the ID instruction, so any hazard it had is moot.
    assign flush = ex_taken && ex_valid;
    assign stall = hazard && !flush;

    assign fwd_a_sel = FWD_EN ? fwd_sel(ex_rs1, mem_valid && mem_rf_we && !mem_is_lw, mem_rd,
                                        wb_valid && wb_rf_we_q, wb_rd_q) : 2'd0;
    assign fwd_b_sel = FWD_EN ? fwd_sel(ex_rs2, mem_valid && mem_rf_we && !mem_is_lw, mem_rd,
                                        wb_valid && wb_rf_we_q, wb_rd_q) : 2'd0;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the shift is order-independent.
    // NOTE: only the valid bits need reset; payloads are cleared too so a
    // bubble always carries an all-zero control word.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_cw        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            mem_valid    <= 1'b0;
            mem_ram_we_q <= 1'b0;
            mem_rf_we    <= 1'b0;
            mem_rf_wsel  <= WB_ALU;
            mem_rd       <= '0;
            mem_is_lw    <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rf_we_q   <= 1'b0;
            wb_rf_wsel_q <= WB_ALU;
            wb_rd_q      <= '0;
        end else begin
            if (stall || flush || !id_valid || !id_legal) begin
                ex_valid <= 1'b0;
                ex_cw    <= '0;
                ex_rs1   <= '0;
                ex_rs2   <= '0;
            end else begin
                ex_valid <= 1'b1;
                ex_cw    <= id_cw;
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
            end
            mem_valid    <= ex_valid;
            mem_ram_we_q <= ex_cw.ram_we;
            mem_rf_we    <= ex_cw.rf_we;
            mem_rf_wsel  <= ex_cw.rf_wsel;
            mem_rd       <= ex_cw.rd;
            mem_is_lw    <= ex_cw.is_lw;
            wb_valid     <= mem_valid;
            wb_rf_we_q   <= mem_rf_we;
            wb_rf_wsel_q <= mem_rf_wsel;
            wb_rd_q      <= mem_rd;
        end
    end

    assign ex_npc_sel     = ex_valid ? ex_cw.npc_sel : NPC_PC4;
    assign ex_alu_op      = ex_cw.alu_op;
    assign ex_alu_opB_sel = ex_cw.opb_sel;
    assign mem_ram_we     = mem_valid && mem_ram_we_q;
    assign wb_rf_we       = wb_valid && wb_rf_we_q;
    assign wb_rf_wsel     = wb_rf_wsel_q;
    assign wb_rd          = wb_rd_q;
endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: one forwarding and one stalling instance
// share the ID-side stimulus; each scenario checks the instance it targets.
module tb_pipe_control;
    localparam logic [31:0] ADD_3_1_2  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] SUB_4_3_1  = {7'b0100000, 5'd1, 5'd3, 3'b000, 5'd4, 7'b0110011};
    localparam logic [31:0] LW_5_0_1   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] ADD_6_5_5  = {7'b0000000, 5'd5, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] ADDI_7_0_1 = {12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011};
    localparam logic [31:0] ADD_8_7_0  = {7'b0000000, 5'd0, 5'd7, 3'b000, 5'd8, 7'b0110011};
    localparam logic [31:0] BEQ_1_2    = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
    localparam logic [31:0] JAL_1      = {20'h00010, 5'd1, 7'b1101111};
    localparam logic [31:0] ADDI_0_0_5 = {12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011};
    localparam logic [31:0] ADD_1_0_0  = {7'b0000000, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0110011};
    localparam logic [31:0] SW_2_0_1   = {7'b0000000, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011};
    localparam logic [31:0] LUI_9      = {20'h12345, 5'd9, 7'b0110111};
    localparam logic [31:0] BAD_OP     = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_inst;
    logic        id_valid, ex_taken;

    logic [1:0] f_ex_npc_sel, f_wb_rf_wsel, f_fwd_a_sel, f_fwd_b_sel;
    logic [3:0] f_ex_alu_op;
    logic [2:0] f_id_sext_op;
    logic [4:0] f_wb_rd;
    logic       f_ex_alu_opB_sel, f_mem_ram_we, f_wb_rf_we, f_stall, f_flush, f_illegal;

    logic [1:0] s_ex_npc_sel, s_wb_rf_wsel, s_fwd_a_sel, s_fwd_b_sel;
    logic [3:0] s_ex_alu_op;
    logic [2:0] s_id_sext_op;
    logic [4:0] s_wb_rd;
    logic       s_ex_alu_opB_sel, s_mem_ram_we, s_wb_rf_we, s_stall, s_flush, s_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_control #(.FWD_EN(1'b1), .XREGS(32)) u_fwd (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .ex_taken(ex_taken),
        .ex_npc_sel(f_ex_npc_sel), .ex_alu_op(f_ex_alu_op), .ex_alu_opB_sel(f_ex_alu_opB_sel),
        .id_sext_op(f_id_sext_op), .mem_ram_we(f_mem_ram_we), .wb_rf_we(f_wb_rf_we),
        .wb_rf_wsel(f_wb_rf_wsel), .wb_rd(f_wb_rd), .fwd_a_sel(f_fwd_a_sel), .fwd_b_sel(f_fwd_b_sel),
        .stall(f_stall), .flush(f_flush), .illegal(f_illegal)
    );

    pipe_control #(.FWD_EN(1'b0), .XREGS(32)) u_stl (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .ex_taken(ex_taken),
        .ex_npc_sel(s_ex_npc_sel), .ex_alu_op(s_ex_alu_op), .ex_alu_opB_sel(s_ex_alu_opB_sel),
        .id_sext_op(s_id_sext_op), .mem_ram_we(s_mem_ram_we), .wb_rf_we(s_wb_rf_we),
        .wb_rf_wsel(s_wb_rf_wsel), .wb_rd(s_wb_rd), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
        .stall(s_stall), .flush(s_flush), .illegal(s_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic v, input logic t);
        id_inst  = inst;
        id_valid = v;
        ex_taken = t;
        #1;
    endtask

    task automatic idle();
        drive(32'd0, 1'b0, 1'b0);
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(32'd0, 1'b0, 1'b0);
        tick();
        check("rst_wb_rf_we", f_wb_rf_we, 0);
        check("rst_mem_ram_we", f_mem_ram_we, 0);
        check("rst_npc_sel", f_ex_npc_sel, 0);
        check("rst_fwd_a", f_fwd_a_sel, 0);
        check("rst_stall", f_stall, 0);
        check("rst_flush", f_flush, 0);
        rst = 1'b0;

        // add x3,x1,x2 ; sub x4,x3,x1 with forwarding
        drive(ADD_3_1_2, 1'b1, 1'b0);
        check("raw_c0_stall", f_stall, 0);
        tick();
        drive(SUB_4_3_1, 1'b1, 1'b0);
        check("raw_c1_stall", f_stall, 0);
        check("raw_c1_alu_add", f_ex_alu_op, 0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        check("raw_fwd_a_mem", f_fwd_a_sel, 1);
        check("raw_fwd_b_none", f_fwd_b_sel, 0);
        check("raw_alu_sub", f_ex_alu_op, 1);
        tick();
        check("raw_wb_we", f_wb_rf_we, 1);
        check("raw_wb_rd", f_wb_rd, 3);
        check("raw_wb_wsel", f_wb_rf_wsel, 0);
        tick();
        check("raw_wb_rd_sub", f_wb_rd, 4);
        idle();

        // lw x5,0(x1) ; add x6,x5,x5 -> one stall, bubble, then WB forwarding
        drive(LW_5_0_1, 1'b1, 1'b0);
        check("lu_sext_i", f_id_sext_op, 0);
        tick();
        drive(ADD_6_5_5, 1'b1, 1'b0);
        check("lu_stall", f_stall, 1);
        check("lu_flush", f_flush, 0);
        check("lu_lw_opb", f_ex_alu_opB_sel, 1);
        tick();
        drive(ADD_6_5_5, 1'b1, 1'b0);
        check("lu_stall_once", f_stall, 0);
        check("lu_bubble_opb", f_ex_alu_opB_sel, 0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        check("lu_fwd_a_wb", f_fwd_a_sel, 2);
        check("lu_fwd_b_wb", f_fwd_b_sel, 2);
        check("lu_wb_wsel_ram", f_wb_rf_wsel, 1);
        check("lu_wb_rd", f_wb_rd, 5);
        idle();

        // FWD_EN=0: addi x7,x0,1 ; add x8,x7,x0 -> two stall cycles
        drive(ADDI_7_0_1, 1'b1, 1'b0);
        check("st_c0_stall", s_stall, 0);
        tick();
        drive(ADD_8_7_0, 1'b1, 1'b0);
        check("st_c1_stall", s_stall, 1);
        check("st_c1_fwd_a", s_fwd_a_sel, 0);
        tick();
        drive(ADD_8_7_0, 1'b1, 1'b0);
        check("st_c2_stall", s_stall, 1);
        tick();
        drive(ADD_8_7_0, 1'b1, 1'b0);
        check("st_c3_stall", s_stall, 0);
        check("st_c3_wb_rd", s_wb_rd, 7);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        check("st_fwd_a", s_fwd_a_sel, 0);
        check("st_fwd_b", s_fwd_b_sel, 0);
        idle();

        // FWD_EN=0: taken beq in EX while add in ID hits lw in MEM
        drive(LW_5_0_1, 1'b1, 1'b0);
        tick();
        drive(BEQ_1_2, 1'b1, 1'b0);
        check("br_c1_stall", s_stall, 0);
        check("br_sext_b", s_id_sext_op, 2);
        tick();
        drive(ADD_6_5_5, 1'b1, 1'b1);
        check("br_flush", s_flush, 1);
        check("br_stall_overridden", s_stall, 0);
        check("br_npc_br", s_ex_npc_sel, 1);
        check("br_alu_beq", s_ex_alu_op, 10);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        check("br_bubble_npc", s_ex_npc_sel, 0);
        check("br_flush_drop", s_flush, 0);
        tick();
        check("br_wb_we", s_wb_rf_we, 0);
        idle();

        // jal x1 redirect: link write survives, discarded add never writes
        drive(JAL_1, 1'b1, 1'b0);
        check("j_sext_j", f_id_sext_op, 4);
        tick();
        drive(ADD_6_5_5, 1'b1, 1'b1);
        check("j_flush", f_flush, 1);
        check("j_npc_jal", f_ex_npc_sel, 2);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        check("j_bubble_npc", f_ex_npc_sel, 0);
        tick();
        check("j_wb_we", f_wb_rf_we, 1);
        check("j_wb_wsel_pc4", f_wb_rf_wsel, 2);
        check("j_wb_rd", f_wb_rd, 1);
        tick();
        check("j_discard_wb_we", f_wb_rf_we, 0);
        idle();

        // x0 destination / sources: no write, no forward, no stall
        drive(ADDI_0_0_5, 1'b1, 1'b0);
        tick();
        drive(ADD_1_0_0, 1'b1, 1'b0);
        check("x0_f_stall", f_stall, 0);
        check("x0_s_stall_ex", s_stall, 0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        check("x0_fwd_a", f_fwd_a_sel, 0);
        check("x0_fwd_b", f_fwd_b_sel, 0);
        tick();
        check("x0_wb_we", f_wb_rf_we, 0);
        idle();

        // sw then lui: store enable in MEM, lui writes ext value
        drive(SW_2_0_1, 1'b1, 1'b0);
        check("sw_sext_s", f_id_sext_op, 1);
        tick();
        drive(LUI_9, 1'b1, 1'b0);
        check("lui_sext_u", f_id_sext_op, 3);
        check("sw_opb_ext", f_ex_alu_opB_sel, 1);
        check("lui_no_stall", f_stall, 0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        check("sw_ram_we", f_mem_ram_we, 1);
        tick();
        check("sw_wb_we", f_wb_rf_we, 0);
        check("lui_ram_we", f_mem_ram_we, 0);
        tick();
        check("lui_wb_we", f_wb_rf_we, 1);
        check("lui_wb_wsel", f_wb_rf_wsel, 3);
        check("lui_wb_rd", f_wb_rd, 9);
        idle();

        // Unknown opcode: illegal only when valid, then a bubble
        drive(BAD_OP, 1'b0, 1'b0);
        check("ill_invalid", f_illegal, 0);
        drive(BAD_OP, 1'b1, 1'b0);
        check("ill_valid", f_illegal, 1);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        check("ill_npc", f_ex_npc_sel, 0);
        check("ill_opb", f_ex_alu_opB_sel, 0);
        tick();
        check("ill_ram_we", f_mem_ram_we, 0);
        tick();
        check("ill_wb_we", f_wb_rf_we, 0);
        idle();

        // Reset in the middle of a load-use stall
        drive(LW_5_0_1, 1'b1, 1'b0);
        tick();
        drive(ADD_6_5_5, 1'b1, 1'b0);
        check("rs_stall_before", f_stall, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(ADD_6_5_5, 1'b1, 1'b0);
        check("rs_stall_abort", f_stall, 0);
        check("rs_wb_we", f_wb_rf_we, 0);
        check("rs_ram_we", f_mem_ram_we, 0);
        check("rs_npc", f_ex_npc_sel, 0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        check("rs_fwd_a", f_fwd_a_sel, 0);
        check("rs_fwd_b", f_fwd_b_sel, 0);
        tick();
        check("rs_wb_not_yet", f_wb_rf_we, 0);
        tick();
        check("rs_refill_wb_we", f_wb_rf_we, 1);
        check("rs_refill_wb_rd", f_wb_rd, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
